noc_prio_arbiter: RTL

Parametrised N-input packet arbiter for router output ports, next generation of the 2-input fixed-priority arbiter. Selectable fixed-priority or round-robin policy, registered one-hot grant, and a wormhole lock that holds the grant from head flit to tail flit. Instantiated once per router output port, between the input-buffer request lines and the output crossbar select.

---
 rtl/noc_prio_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/noc_prio_arbiter.sv
// N-input wormhole packet arbiter: fixed-priority or round-robin winner, grant locked head-to-tail.
// Latency: 1 cycle request-to-grant; 0 idle cycles from tail handshake to next grant.
// Backpressure: grant is held for any number of stalled cycles until hs_i & last_i.
module noc_prio_arbiter #(
   parameter int N_REQ   = 4,
   parameter int RR_MODE = 0,
   parameter int IDX_W   = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [N_REQ-1:0] req_i,
   input  logic             hs_i,
   input  logic             last_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             busy_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand_idx;
   logic [IDX_W-1:0] win_idx;
   logic             win_vld;
   logic [N_REQ-1:0] win_oh;
   logic [IDX_W-1:0] ptr_nxt;
   logic             load;

   // Pick the winner: scan from the start index (0 or ptr) upward with wrap.
   // The loop runs from the far end back so the closest match is written last.
   always_comb begin
      int cand;
      win_vld  = 1'b0;
      win_idx  = '0;
      cand_idx = '0;
      cand     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = (RR_MODE != 0) ? int'(ptr) + k : k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (req_i[cand_idx]) begin
            win_vld = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   // One-hot winner, next round-robin pointer with explicit wrap, and the
   // condition under which a new arbitration result may be registered.
   always_comb begin
      win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
      ptr_nxt = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      load    = (state == IDLE) || (hs_i && last_i);
   end

   // Arbitration FSM: grab a winner when idle or on the tail handshake,
   // otherwise freeze the grant regardless of req_i.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         grant_o     <= '0;
         grant_idx_o <= '0;
         busy_o      <= 1'b0;
      end else if (load) begin
         if (win_vld) begin
            state       <= LOCKED;
            grant_o     <= win_oh;
            grant_idx_o <= win_idx;
            busy_o      <= 1'b1;
            if (RR_MODE != 0) begin
               ptr <= ptr_nxt;
            end
         end else begin
            state       <= IDLE;
            grant_o     <= '0;
            grant_idx_o <= '0;
            busy_o      <= 1'b0;
         end
      end
   end

endmodule
